// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of a single shared memory port.
// m0 is the instruction side and m1 is the data side. Ties are broken round-robin.
// Grant is held for the whole master cycle, including bursts.
// A per-grant watchdog aborts a strobe that the memory never answers.
module wb_mem_arbiter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic [2:0]  wb_cti_o,
    output logic [1:0]  wb_bte_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,

    output logic [1:0]  gnt_o
);

    localparam int unsigned WD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT0  = 2'd1,
        GNT1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last_m1;     // 1: m1 was granted most recently
    logic [WD_W-1:0] r_wdog;
    logic [WD_W-1:0] w_wdog_nxt;
    logic [1:0]      r_gnt;
    logic            w_granted;
    logic            w_rsp;
    logic            w_wait;
    logic            w_wdog_hit;

    assign w_granted = (r_state == GNT0) || (r_state == GNT1);
    assign w_rsp     = wb_ack_i | wb_err_i | wb_rty_i;
    assign w_wait    = w_granted && wb_stb_o && !w_rsp;
    // The ABORT cycle itself is the TIMEOUT-th unanswered cycle, so the decision
    // is taken at the end of the (TIMEOUT-1)-th waiting cycle in the grant state.
    assign w_wdog_hit = w_wait && (r_wdog == WD_W'(TIMEOUT - 2));

    // State, round-robin pointer, watchdog and registered grant decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last_m1 <= 1'b1;
            r_wdog    <= '0;
            r_gnt     <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_wdog  <= w_wdog_nxt;
            r_gnt   <= {w_state_nxt == GNT1, w_state_nxt == GNT0};
            if (w_state_nxt == GNT0) begin
                r_last_m1 <= 1'b0;
            end else if (w_state_nxt == GNT1) begin
                r_last_m1 <= 1'b1;
            end
        end
    end

    // Next-state and watchdog update
    always_comb begin
        w_state_nxt = r_state;
        w_wdog_nxt  = '0;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_m1 ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = GNT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (w_wdog_hit) begin
                    w_state_nxt = ABORT;
                end else if (w_wait) begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = IDLE;
                end else if (w_wdog_hit) begin
                    w_state_nxt = ABORT;
                end else if (w_wait) begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end
            end
            ABORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Request mux to memory and response demux to the granted master
    always_comb begin
        wb_cyc_o = 1'b0;
        wb_stb_o = 1'b0;
        wb_we_o  = 1'b0;
        wb_adr_o = '0;
        wb_dat_o = '0;
        wb_sel_o = '0;
        wb_cti_o = '0;
        wb_bte_o = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        case (r_state)
            GNT0: begin
                wb_cyc_o = m0_cyc_i;
                wb_stb_o = m0_stb_i;
                wb_we_o  = m0_we_i;
                wb_adr_o = m0_adr_i;
                wb_dat_o = m0_dat_i;
                wb_sel_o = m0_sel_i;
                wb_cti_o = m0_cti_i;
                wb_bte_o = m0_bte_i;
                m0_dat_o = wb_dat_i;
                m0_ack_o = wb_ack_i;
                m0_err_o = wb_err_i;
                m0_rty_o = wb_rty_i;
            end
            GNT1: begin
                wb_cyc_o = m1_cyc_i;
                wb_stb_o = m1_stb_i;
                wb_we_o  = m1_we_i;
                wb_adr_o = m1_adr_i;
                wb_dat_o = m1_dat_i;
                wb_sel_o = m1_sel_i;
                wb_cti_o = m1_cti_i;
                wb_bte_o = m1_bte_i;
                m1_dat_o = wb_dat_i;
                m1_ack_o = wb_ack_i;
                m1_err_o = wb_err_i;
                m1_rty_o = wb_rty_i;
            end
            ABORT: begin
                // The pointer still names the master whose strobe timed out
                m0_err_o = !r_last_m1;
                m1_err_o = r_last_m1;
            end
            default: begin
            end
        endcase
    end

    assign gnt_o = r_gnt;

endmodule
